// File: rtl/button_pkg.sv
// button_pkg: shared types and constants for the button conditioner.
// Holds the per-channel debounce state enum, the button index map and
// the default timing constants (36 MHz pixel clock).
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    CONFIRM_PRESS,
    PRESSED,
    CONFIRM_RELEASE
  } btn_state_t;

  // Bit positions in the button vectors, LSB = c.
  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_R = 3;
  localparam int BTN_L = 4;

  localparam int N_BTN_DEFAULT           = 5;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 360000;   // 10 ms
  localparam int REPEAT_DELAY_DEFAULT    = 14400000; // 400 ms
  localparam int REPEAT_PERIOD_DEFAULT   = 3600000;  // 100 ms

  // A channel reports the button as held while a release is still unconfirmed.
  function automatic logic state_is_held(input btn_state_t st);
    return (st == PRESSED) || (st == CONFIRM_RELEASE);
  endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// button_debounce_channel: one button bit.
// 2-flop synchroniser, four-state debounce FSM with a consecutive-sample
// counter, registered press/release strobes. With BUTTON_AUTOREPEAT_EN
// defined, a repeat counter adds auto-repeat strobes to o_press while held.
module button_debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
  input  logic clk,
  input  logic arst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int              DW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0]   D_ONE    = DW'(1);
  localparam logic [DW-1:0]   D_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam bit              D_SINGLE = (DEBOUNCE_CYCLES == 1);

  logic          r_sync1;
  logic          r_sync2;
  btn_state_t    r_state;
  btn_state_t    w_state_next;
  logic [DW-1:0] r_dcnt;
  logic [DW-1:0] w_dcnt_next;
  logic          w_accept_press;
  logic          w_accept_release;
  logic          w_level;
  logic          w_repeat;
  logic          r_press;
  logic          r_release;

  assign w_level = state_is_held(r_state);

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce state and stable-sample counter.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= RELEASED;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_dcnt  <= w_dcnt_next;
    end
  end

  // Next state: a change is accepted on the DEBOUNCE_CYCLES-th consecutive
  // opposite sample; any sample agreeing with the current level restarts it.
  always_comb begin
    w_state_next     = r_state;
    w_dcnt_next      = r_dcnt;
    w_accept_press   = 1'b0;
    w_accept_release = 1'b0;
    case (r_state)
      RELEASED: begin
        if (r_sync2) begin
          if (D_SINGLE) begin
            w_state_next   = PRESSED;
            w_dcnt_next    = '0;
            w_accept_press = 1'b1;
          end else begin
            w_state_next = CONFIRM_PRESS;
            w_dcnt_next  = D_ONE;
          end
        end
      end
      CONFIRM_PRESS: begin
        if (!r_sync2) begin
          w_state_next = RELEASED;
          w_dcnt_next  = '0;
        end else if (r_dcnt == D_LAST) begin
          w_state_next   = PRESSED;
          w_dcnt_next    = '0;
          w_accept_press = 1'b1;
        end else begin
          w_dcnt_next = r_dcnt + D_ONE;
        end
      end
      PRESSED: begin
        if (!r_sync2) begin
          if (D_SINGLE) begin
            w_state_next     = RELEASED;
            w_dcnt_next      = '0;
            w_accept_release = 1'b1;
          end else begin
            w_state_next = CONFIRM_RELEASE;
            w_dcnt_next  = D_ONE;
          end
        end
      end
      CONFIRM_RELEASE: begin
        if (r_sync2) begin
          w_state_next = PRESSED;
          w_dcnt_next  = '0;
        end else if (r_dcnt == D_LAST) begin
          w_state_next     = RELEASED;
          w_dcnt_next      = '0;
          w_accept_release = 1'b1;
        end else begin
          w_dcnt_next = r_dcnt + D_ONE;
        end
      end
      default: begin
        w_state_next = RELEASED;
        w_dcnt_next  = '0;
      end
    endcase
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int            RW      = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam logic [RW-1:0] R_ONE   = RW'(1);
  localparam logic [RW-1:0] R_DELAY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_WRAP  = RW'(REPEAT_DELAY + REPEAT_PERIOD - 1);

  logic [RW-1:0] r_rcnt;
  logic [RW-1:0] w_rcnt_next;
  logic [RW-1:0] w_rcnt_inc;

  assign w_rcnt_inc = r_rcnt + R_ONE;

  // Repeat timing: count up to the first-repeat point, then fold back by one
  // period at each later repeat so the counter never grows past one period.
  always_comb begin
    w_rcnt_next = r_rcnt;
    w_repeat    = 1'b0;
    if (w_accept_press || w_accept_release || !w_level) begin
      w_rcnt_next = '0;
    end else if (r_rcnt == R_WRAP) begin
      w_rcnt_next = R_DELAY;
      w_repeat    = 1'b1;
    end else begin
      w_rcnt_next = w_rcnt_inc;
      w_repeat    = (w_rcnt_inc == R_DELAY);
    end
  end

  // Repeat counter register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rcnt <= '0;
    end else begin
      r_rcnt <= w_rcnt_next;
    end
  end
`else
  assign w_repeat = 1'b0;
`endif

  // Strobes land in the same cycle the level output changes.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= w_accept_press | w_repeat;
      r_release <= w_accept_release;
    end
  end

  assign o_level   = w_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: raw board buttons -> clean level and strobe signals
// for game_console. One independent debounce channel per button, plus the
// any-press summary. Auto-repeat is compiled in with BUTTON_AUTOREPEAT_EN.
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             btn_any_press
);

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_chan
      button_debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_chan (
        .clk      (clk),
        .arst_n   (arst_n),
        .i_raw    (btn_raw[gi]),
        .o_level  (btn_level[gi]),
        .o_press  (btn_press[gi]),
        .o_release(btn_release[gi])
      );
    end
  endgenerate

  assign btn_any_press = |btn_press;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: table vectors for the basic scenarios, hand-written
// reset and auto-repeat sequences, then random stimulus against a model that
// accepts a change once the last DEBOUNCE_CYCLES synchronised samples all
// disagree with the current level.
module tb_button_conditioner;
  import button_pkg::*;

  localparam int N  = 5;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  localparam logic [N-1:0] M_C = N'(1) << BTN_C;
  localparam logic [N-1:0] M_U = N'(1) << BTN_U;
  localparam logic [N-1:0] M_D = N'(1) << BTN_D;
  localparam logic [N-1:0] M_R = N'(1) << BTN_R;
  localparam logic [N-1:0] M_L = N'(1) << BTN_L;
  localparam logic [N-1:0] Z   = '0;

  logic         clk = 1'b0;
  logic         arst_n;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic         btn_any_press;

  int n_checks = 0;
  int n_fail   = 0;

  button_conditioner #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .btn_press    (btn_press),
    .btn_release  (btn_release),
    .btn_any_press(btn_any_press)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // m_hist[c] bit k = raw value sampled k edges ago (bit 0 = this edge).
  logic [DB+1:0] m_hist [N];
  logic [N-1:0]  m_level, m_press, m_rel;
  int            m_held [N];

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_hist[c] = '0;
      m_held[c] = 0;
    end
    m_level = '0;
    m_press = '0;
    m_rel   = '0;
  endtask

  task automatic model_edge();
    for (int c = 0; c < N; c++) begin
      bit flip;
      m_press[c] = 1'b0;
      m_rel[c]   = 1'b0;
      m_hist[c]  = {m_hist[c][DB:0], btn_raw[c]};
      // The FSM sees raw delayed by two edges: samples 2..DB+1 are its window.
      flip = 1'b1;
      for (int k = 2; k <= DB + 1; k++)
        if (m_hist[c][k] == m_level[c]) flip = 1'b0;
      if (flip) begin
        m_level[c] = ~m_level[c];
        m_held[c]  = 0;
        if (m_level[c]) m_press[c] = 1'b1;
        else            m_rel[c]   = 1'b1;
      end else if (m_level[c]) begin
        m_held[c]++;
`ifdef BUTTON_AUTOREPEAT_EN
        if (m_held[c] >= RD && ((m_held[c] - RD) % RP) == 0) m_press[c] = 1'b1;
`endif
      end
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    if (arst_n) model_edge();
    else        model_reset();
    #1;
  endtask

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [N-1:0] lvl, input logic [N-1:0] prs,
                         input logic [N-1:0] rel);
    chk({tag, "_level"},   btn_level,   lvl);
    chk({tag, "_press"},   btn_press,   prs);
    chk({tag, "_release"}, btn_release, rel);
    chk({tag, "_any"}, {{(N-1){1'b0}}, btn_any_press}, {{(N-1){1'b0}}, |prs});
  endtask

  task automatic chk_model(input string tag);
    chk_all(tag, m_level, m_press, m_rel);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0] raw;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [N-1:0] raw, input int n, input logic [N-1:0] lvl,
                     input logic [N-1:0] prs, input logic [N-1:0] rel);
    vec_t v;
    v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel;
    repeat (n) vecs.push_back(v);
  endtask

  initial begin
    int press_cyc[$];
    int exp_cyc[$];
    int rel_cyc;

    // Scenario 1: single press/release on c.
    add(M_C, 5, Z,   Z,   Z);
    add(M_C, 1, M_C, M_C, Z);
    add(M_C, 2, M_C, Z,   Z);
    add(Z,   5, M_C, Z,   Z);
    add(Z,   1, Z,   Z,   M_C);
    add(Z,   1, Z,   Z,   Z);
    // Scenario 2: short pulse and bounce on d must be rejected.
    add(M_D, 3, Z, Z, Z);
    add(Z,   2, Z, Z, Z);
    add(M_D, 1, Z, Z, Z);
    add(Z,   1, Z, Z, Z);
    add(M_D, 2, Z, Z, Z);
    add(Z,   7, Z, Z, Z);
    // Scenario 3: u held 10 cycles, release 6 cycles after raw falls.
    add(M_U, 5, Z,   Z,   Z);
    add(M_U, 1, M_U, M_U, Z);
    add(M_U, 4, M_U, Z,   Z);
    add(Z,   5, M_U, Z,   Z);
    add(Z,   1, Z,   Z,   M_U);
    add(Z,   2, Z,   Z,   Z);
    // Scenario 4: c and l on the same edge.
    add(M_C | M_L, 5, Z,         Z,         Z);
    add(M_C | M_L, 1, M_C | M_L, M_C | M_L, Z);
    add(M_C | M_L, 2, M_C | M_L, Z,         Z);
    add(Z,         5, M_C | M_L, Z,         Z);
    add(Z,         1, Z,         Z,         M_C | M_L);
    add(Z,         1, Z,         Z,         Z);

    // Reset state.
    model_reset();
    arst_n  = 1'b0;
    btn_raw = '0;
    #1;
    chk_all("reset_async", Z, Z, Z);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("reset_hold", Z, Z, Z);
    end
    arst_n = 1'b1;

    // Table vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      btn_raw = vecs[i].raw;
      step();
      $display("vec %0d: raw=%b level=%b press=%b release=%b any=%b",
               i, vecs[i].raw, btn_level, btn_press, btn_release, btn_any_press);
      chk_all($sformatf("tv%0d", i), vecs[i].lvl, vecs[i].prs, vecs[i].rel);
    end

    // Scenario 5: reset while r is pressed and still held.
    btn_raw = M_R;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_model("s5_pre");
    end
    chk("s5_pressed_before_reset", btn_level, M_R);
    #2;
    arst_n = 1'b0;
    model_reset();
    #1;
    $display("s5: reset asserted, level=%b press=%b release=%b", btn_level, btn_press, btn_release);
    chk_all("s5_reset_now", Z, Z, Z);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("s5_in_reset", Z, Z, Z);
    end
    arst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk_all($sformatf("s5_post%0d", i), (i >= 6) ? M_R : Z, (i == 6) ? M_R : Z, Z);
    end
    $display("s5: fresh press after reset, level=%b", btn_level);
    btn_raw = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_model("s5_rel");
    end

    // Scenario 6: c held for 50 cycles, record press strobes.
    rel_cyc = -1;
    btn_raw = M_C;
    for (int cyc = 1; cyc <= 62; cyc++) begin
      if (cyc == 51) btn_raw = '0;
      step();
      chk_model("s6");
      if (btn_press[BTN_C]) begin
        press_cyc.push_back(cyc);
        $display("s6: press strobe at cycle %0d", cyc);
      end
      if (btn_release[BTN_C]) rel_cyc = cyc;
    end
`ifdef BUTTON_AUTOREPEAT_EN
    exp_cyc = '{6, 26, 34, 42, 50};
`else
    exp_cyc = '{6};
`endif
    chk_int("s6_press_count", press_cyc.size(), exp_cyc.size());
    for (int i = 0; i < exp_cyc.size(); i++)
      chk_int($sformatf("s6_press_cycle%0d", i), (i < press_cyc.size()) ? press_cyc[i] : -1, exp_cyc[i]);
    chk_int("s6_release_cycle", rel_cyc, 56);

    // Random stimulus against the model, with one reset in the middle.
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 5) == 0) btn_raw[c] = ~btn_raw[c];
      if (i == 750) begin
        arst_n = 1'b0;
        model_reset();
        #1;
        chk_all("rand_reset_now", Z, Z, Z);
      end
      if (i == 753) arst_n = 1'b1;
      step();
      chk_model("rand");
      if ((|btn_press) || (|btn_release))
        $display("rand %0d: level=%b press=%b release=%b", i, btn_level, btn_press, btn_release);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
